// File: rtl/mem_stage_if.sv
// mem_stage_if: data-bus connection between the memory stage and the memory
// system.
//   master (memory stage): drives bus_req, bus_we, bus_addr, bus_sel and
//                          bus_wdata; receives bus_rdata and bus_ack.
//   slave  (memory side) : the mirror image of master.
interface mem_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with a big-endian 32-bit data bus.
// Non-memory results pass through in one cycle. Aligned loads and stores run
// one bus transaction. A misaligned access is rejected with align_err. A bus
// that stays silent for 16 cycles is abandoned with bus_err.
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   valid_in, wd_in, wreg_in, wdata_in, aluop_in, mem_addr_in, reg2_in
//                      execute-stage result and memory operands
//   wd_out, wreg_out, wdata_out, valid_out
//                      registered write-back result
//   stall_req          combinational; asks upstream to hold its inputs
//   align_err, bus_err registered error pulses that coincide with valid_out
//   bus                data-bus master port (mem_stage_if.master)
module mem_stage (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [4:0]         wd_in,
    input  logic               wreg_in,
    input  logic [31:0]        wdata_in,
    input  logic [7:0]         aluop_in,
    input  logic [31:0]        mem_addr_in,
    input  logic [31:0]        reg2_in,
    output logic [4:0]         wd_out,
    output logic               wreg_out,
    output logic [31:0]        wdata_out,
    output logic               valid_out,
    output logic               stall_req,
    output logic               align_err,
    output logic               bus_err,
    mem_stage_if.master        bus
);
    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_NONE = 2'd3;

    localparam logic [3:0] LAST_WAIT = 4'd15;

    typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

    function automatic logic [1:0] op_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
            OP_LW, OP_SW:         op_size = SZ_WORD;
            default:              op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Byte address 0 of a word is the most significant lane (big-endian).
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: lane_sel = 4'b1000 >> lo;
            SZ_HALF: lane_sel = lo[1] ? 4'b0011 : 4'b1100;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    // Replicating the store data lets the memory pick it up from any lane.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] reg2);
        case (size)
            SZ_BYTE: store_data = {4{reg2[7:0]}};
            SZ_HALF: store_data = {2{reg2[15:0]}};
            default: store_data = reg2;
        endcase
    endfunction

    function automatic logic [31:0] load_data(input logic [7:0] op, input logic [1:0] lo,
                                              input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = rdata[31:24];
            2'd1:    b = rdata[23:16];
            2'd2:    b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = lo[1] ? rdata[15:0] : rdata[31:16];
        case (op)
            OP_LB:   load_data = {{24{b[7]}}, b};
            OP_LBU:  load_data = {24'd0, b};
            OP_LH:   load_data = {{16{h[15]}}, h};
            OP_LHU:  load_data = {16'd0, h};
            default: load_data = rdata;
        endcase
    endfunction

    state_t      state_r;
    logic [3:0]  wait_cnt_r;
    logic [7:0]  op_r;
    logic [4:0]  wd_r;
    logic        wreg_r;
    logic [1:0]  lo_r;
    logic        bus_req_r;
    logic        bus_we_r;
    logic [31:0] bus_addr_r;
    logic [3:0]  bus_sel_r;
    logic [31:0] bus_wdata_r;
    logic [1:0]  size_s;
    logic        mem_op_s;
    logic        misalign_s;

    assign bus.bus_req   = bus_req_r;
    assign bus.bus_we    = bus_we_r;
    assign bus.bus_addr  = bus_addr_r;
    assign bus.bus_sel   = bus_sel_r;
    assign bus.bus_wdata = bus_wdata_r;

    // Decode the incoming operation: access size, memory-op flag and alignment.
    always_comb begin
        size_s     = op_size(aluop_in);
        mem_op_s   = valid_in && (size_s != SZ_NONE);
        misalign_s = ((size_s == SZ_HALF) && mem_addr_in[0]) ||
                     ((size_s == SZ_WORD) && (mem_addr_in[1:0] != 2'b00));
    end

    // Hold upstream while a bus access is being issued or is still unanswered.
    always_comb begin
        stall_req = 1'b0;
        if (rst) begin
            stall_req = 1'b0;
        end else if (state_r == BUS) begin
            stall_req = ~bus.bus_ack;
        end else if (mem_op_s && !misalign_s) begin
            stall_req = 1'b1;
        end else begin
            stall_req = 1'b0;
        end
    end

    // Stage FSM: pass-through, bus issue, response/timeout and write-back registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 4'd0;
            op_r        <= 8'd0;
            wd_r        <= 5'd0;
            wreg_r      <= 1'b0;
            lo_r        <= 2'd0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_sel_r   <= 4'd0;
            bus_wdata_r <= 32'd0;
            wd_out      <= 5'd0;
            wreg_out    <= 1'b0;
            wdata_out   <= 32'd0;
            valid_out   <= 1'b0;
            align_err   <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bus_err <= 1'b0;
                    if (mem_op_s && misalign_s) begin
                        // Rejected without touching the bus; nothing is written back.
                        valid_out <= 1'b1;
                        align_err <= 1'b1;
                        wreg_out  <= 1'b0;
                        wd_out    <= wd_in;
                        wdata_out <= 32'd0;
                    end else if (mem_op_s) begin
                        valid_out   <= 1'b0;
                        align_err   <= 1'b0;
                        wreg_out    <= 1'b0;
                        op_r        <= aluop_in;
                        wd_r        <= wd_in;
                        wreg_r      <= wreg_in;
                        lo_r        <= mem_addr_in[1:0];
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= is_store(aluop_in);
                        bus_addr_r  <= {mem_addr_in[31:2], 2'b00};
                        bus_sel_r   <= lane_sel(size_s, mem_addr_in[1:0]);
                        bus_wdata_r <= store_data(size_s, reg2_in);
                        wait_cnt_r  <= 4'd0;
                        state_r     <= BUS;
                    end else if (valid_in) begin
                        valid_out <= 1'b1;
                        align_err <= 1'b0;
                        wd_out    <= wd_in;
                        wreg_out  <= wreg_in;
                        wdata_out <= wdata_in;
                    end else begin
                        valid_out <= 1'b0;
                        align_err <= 1'b0;
                        wreg_out  <= 1'b0;
                    end
                end
                BUS: begin
                    align_err <= 1'b0;
                    if (bus.bus_ack) begin
                        bus_req_r <= 1'b0;
                        state_r   <= IDLE;
                        valid_out <= 1'b1;
                        bus_err   <= 1'b0;
                        wd_out    <= wd_r;
                        if (is_store(op_r)) begin
                            wreg_out  <= 1'b0;
                            wdata_out <= 32'd0;
                        end else begin
                            wreg_out  <= wreg_r;
                            wdata_out <= load_data(op_r, lo_r, bus.bus_rdata);
                        end
                    end else if (wait_cnt_r == LAST_WAIT) begin
                        // Sixteenth silent cycle: give up on the bus.
                        bus_req_r <= 1'b0;
                        state_r   <= IDLE;
                        valid_out <= 1'b1;
                        bus_err   <= 1'b1;
                        wreg_out  <= 1'b0;
                        wd_out    <= wd_r;
                        wdata_out <= 32'd0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 4'd1;
                        valid_out  <= 1'b0;
                        bus_err    <= 1'b0;
                        wreg_out   <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bus_req_r <= 1'b0;
                    valid_out <= 1'b0;
                    wreg_out  <= 1'b0;
                    align_err <= 1'b0;
                    bus_err   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL expose: clk  in  1  rising-edge clock.
REQ-002 SHALL expose: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL expose: valid_in  in  1  execute-stage result present this cycle.
REQ-004 SHALL expose: wd_in  in  5, wreg_in  in  1, wdata_in  in  32  destination, write flag and result from execute.
REQ-005 SHALL expose: aluop_in  in  8  sub-op. LB=E0, LH=E1, LW=E3, LBU=E4, LHU=E5, SB=E8, SH=E9, SW=EB (hex); anything else is non-memory.
REQ-006 SHALL expose: mem_addr_in  in  32  byte address; reg2_in  in  32  store data.
REQ-007 SHALL expose: wd_out  out  5, wreg_out  out  1, wdata_out  out  32, valid_out  out  1  registered write-back outputs.
REQ-008 SHALL expose: stall_req  out  1  combinational; high = upstream holds its inputs stable.
REQ-009 SHALL expose: align_err  out  1, bus_err  out  1  registered one-cycle error pulses, aligned with valid_out.
REQ-010 SHALL expose: bus_req  out  1, bus_we  out  1, bus_addr  out  32 (bits [1:0]=0), bus_sel  out  4, bus_wdata  out  32  registered.
REQ-011 SHALL expose: bus_rdata  in  32, bus_ack  in  1  data-bus responses.

Function
REQ-012 SHALL implement FSM states IDLE and BUS, plus a 4-bit wait counter.
REQ-013 In IDLE with valid_in and a non-memory op, SHALL register wd/wreg/wdata next edge with valid_out=1 and stall_req=0.
REQ-014 In IDLE without valid_in, SHALL drive valid_out=0 and wreg_out=0 next cycle.
REQ-015 Misaligned ops (H/HU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL issue no bus cycle, hold stall_req=0, and give valid_out=1, align_err=1, wreg_out=0 next cycle.
REQ-016 An aligned memory op in IDLE SHALL raise stall_req that cycle. It SHALL latch wd, wreg, op and addr, then enter BUS next edge with bus_req=1.
REQ-017 Byte lanes SHALL be big-endian. SB sel = 1000/0100/0010/0001 for addr[1:0] = 00/01/10/11. SH sel = 1100/0011 for 00/10. Word sel = 1111. Loads use the same sel.
REQ-018 Store data SHALL be replicated: SB {4{reg2[7:0]}}, SH {2{reg2[15:0]}}, SW reg2. bus_we=1 for stores only.
REQ-019 In BUS, the request fields SHALL stay constant until the transaction ends. stall_req SHALL equal ~bus_ack.
REQ-020 bus_ack in BUS SHALL, at that edge, drop bus_req, return to IDLE, and register results so valid_out=1 next cycle.
REQ-021 Load results: LB/LH sign-extend the selected lane; LBU/LHU zero-extend it; LW passes bus_rdata. wreg_out = latched wreg.
REQ-022 Stores SHALL force wreg_out=0.
REQ-023 Each BUS cycle without ack SHALL increment the counter. An ack on the 16th BUS cycle is accepted. If the 16th BUS cycle ends with no ack, the block SHALL drop bus_req and return to IDLE. It SHALL then output valid_out=1, bus_err=1, wreg_out=0 next cycle.
REQ-024 bus_ack outside BUS SHALL be ignored. Inputs SHALL be ignored while in BUS.
REQ-025 Minimum latency: non-memory op 1 cycle; memory op 2 + wait cycles.

Reset
REQ-026 On rst at a clock edge, all outputs SHALL be 0, the state IDLE and the counter 0. This includes an abort mid-BUS: bus_req SHALL drop at that edge and any later ack is ignored.
REQ-027 stall_req SHALL be 0 while rst is high.

Verification
REQ-028 Non-memory op (OR): wd=3, wdata=0x1234 -> next cycle valid_out=1, wd_out=3, wdata_out=0x1234, no bus_req.
REQ-029 LB at addr 0x103 with rdata 0x11223380, ack after 2 wait cycles -> sel=0001, wdata_out=0xFFFFFF80; stall_req high 3 cycles then low.
REQ-030 SH at addr 0x202 with reg2=0xAAAABEEF -> bus_addr=0x200, sel=0011, bus_wdata=0xBEEFBEEF, we=1, wreg_out=0.
REQ-031 LW at addr 0x101 -> no bus_req, align_err pulse, wreg_out=0, stall_req never high.
REQ-032 LHU at addr 0x0 with no ack -> bus_req high for exactly 16 cycles, then bus_err=1, valid_out=1; a late ack is ignored.
REQ-033 rst asserted on the 2nd BUS cycle of an LW -> next cycle bus_req=0, IDLE, outputs 0; a following ack produces no valid_out.
